mig_responder: RTL and testbench
================================

MIG_RESPONDER -- requirements
Module: mig_responder

Interface
REQ-001 SHALL have parameter DRAM_ADDR_WIDTH, default 30, meaning command address width.
REQ-002 SHALL have parameter DRAM_DATA_WIDTH, default 128, meaning data beat width.
REQ-003 SHALL have parameter MEM_DEPTH_LOG, default 10, meaning log2 of backing-store words.
REQ-004 SHALL have parameter BURST_LEN, default 4, meaning beats per command (power of 2).
REQ-005 SHALL have parameter READ_LATENCY, default 8, meaning wait cycles before the first read beat.
REQ-006 SHALL have parameter FIFO_DEPTH_LOG, default 3, meaning log2 of write/read FIFO depth (depth >= BURST_LEN).
REQ-007 SHALL have ports: Clock in 1 system clock; Reset in 1, where reset is asynchronous and active-high.
REQ-008 SHALL have ports: MIGRdy out 1 command accept; MIGEn in 1 command valid; MIGInstr in 3 command; MIGAddr in DRAM_ADDR_WIDTH word address.
REQ-009 SHALL have ports: WrEn in 1 push beat; WrData in DRAM_DATA_WIDTH; WrDataEnd in 1 marks last beat of burst; WrFull out 1 write FIFO full.
REQ-010 SHALL have ports: RdEn in 1 pop beat; RdData out DRAM_DATA_WIDTH; RdEmpty out 1 read FIFO empty; ProtoErr out 1 sticky protocol error.

Function
REQ-011 SHALL accept a command on a rising edge with MIGEn=1 and MIGRdy=1; MIGInstr 3'b000 = write, 3'b001 = read; other encodings are accepted, do nothing, and set ProtoErr.
REQ-012 SHALL implement states IDLE, WRITE, RDWAIT, READ; MIGRdy=1 only in IDLE and, for any command, only when the read FIFO has >= BURST_LEN free entries.
REQ-013 SHALL on write accept go IDLE->WRITE, pop one write-FIFO beat per cycle while the FIFO is non-empty, store beat k at mem[(MIGAddr[MEM_DEPTH_LOG-1:0]+k) mod 2^MEM_DEPTH_LOG], and return to IDLE after beat BURST_LEN-1.
REQ-014 SHALL set ProtoErr when a popped beat has WrDataEnd=1 with k != BURST_LEN-1, or WrDataEnd=0 with k = BURST_LEN-1; the data is still written.
REQ-015 SHALL on read accept go IDLE->RDWAIT for exactly READ_LATENCY cycles, then READ pushing one beat per cycle (same address rule as REQ-013); first beat visible (RdEmpty=0) after edge t0+READ_LATENCY+1, where t0 is the accept edge.
REQ-016 SHALL make the read FIFO first-word-fall-through: RdData is valid whenever RdEmpty=0; RdEn=1 pops on the edge.
REQ-017 SHALL handle write-FIFO push and pop (and read-FIFO push and pop) in the same cycle with the count unchanged.
REQ-018 SHALL drop a WrEn beat while WrFull=1, and ignore RdEn while RdEmpty=1; both set ProtoErr.
REQ-019 SHALL assert WrFull combinationally from count == 2^FIFO_DEPTH_LOG.
REQ-020 SHALL clear ProtoErr only by Reset.

Reset
REQ-021 SHALL, on Reset, drive MIGRdy=0, WrFull=0, RdEmpty=1, RdData=0, ProtoErr=0, state IDLE, both FIFOs flushed; backing memory is not reset.
REQ-022 SHALL, on Reset mid-burst, abandon the burst with no further memory writes or read pushes; MIGRdy=1 on the first edge after release.

Structure
REQ-023 SHALL place the command encodings (MIG_CMD_WRITE, MIG_CMD_READ) and the state encodings in a shared package also used by the ORAM top.
REQ-024 SHALL instantiate one sub-module, sync_fifo (parameterised width/depth, FWFT), twice: write data and read data.

Verification
REQ-025 SHALL check: push 4 beats 0xA0..0xA3 (WrDataEnd on the 4th), write @0x10, then read @0x10 -> RdData 0xA0,0xA1,0xA2,0xA3 in order, ProtoErr=0.
REQ-026 SHALL check: read accepted at cycle 100 with READ_LATENCY=8 -> RdEmpty falls after edge 109; MIGRdy=0 from 101 until the burst ends.
REQ-027 SHALL check: write @0x3FE with MEM_DEPTH_LOG=10 -> beats land at 0x3FE,0x3FF,0x000,0x001 (verified by reads @0x3FE and @0x000).
REQ-028 SHALL check: 9 WrEn with depth 8 and no command -> WrFull=1 after 8; 9th dropped; ProtoErr=1.
REQ-029 SHALL check: WrDataEnd on beat 2 of 4, or MIGInstr=3'b111 -> ProtoErr=1, memory otherwise consistent.
REQ-030 SHALL check: Reset asserted during READ beat 2 -> RdEmpty=1 immediately, no further beats, MIGRdy=1 one edge after release.

Source files
------------

// File: rtl/mig_responder_pkg.sv
// Shared command and state encodings for the MIG responder.
// The ORAM top imports the same definitions.
package mig_responder_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RDWAIT = 2'd2,
    READ   = 2'd3
  } mig_state_t;

endpackage

// File: rtl/mig_responder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. pop_data shows the head entry whenever empty=0.
// A push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full     = (count == (DEPTH_LOG+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (DEPTH_LOG+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_responder.sv
// Behavioural stand-in for a MIG DRAM controller: burst write/read against an on-chip
// backing store, with write/read data FIFOs and a sticky protocol-error flag.
module mig_responder
  import mig_responder_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 30,
  parameter int DRAM_DATA_WIDTH = 128,
  parameter int MEM_DEPTH_LOG   = 10,
  parameter int BURST_LEN       = 4,
  parameter int READ_LATENCY    = 8,
  parameter int FIFO_DEPTH_LOG  = 3
) (
  input  logic                       Clock,
  input  logic                       Reset,
  output logic                       MIGRdy,
  input  logic                       MIGEn,
  input  logic [2:0]                 MIGInstr,
  input  logic [DRAM_ADDR_WIDTH-1:0] MIGAddr,
  input  logic                       WrEn,
  input  logic [DRAM_DATA_WIDTH-1:0] WrData,
  input  logic                       WrDataEnd,
  output logic                       WrFull,
  input  logic                       RdEn,
  output logic [DRAM_DATA_WIDTH-1:0] RdData,
  output logic                       RdEmpty,
  output logic                       ProtoErr,
  output mig_state_t                 dbg_state
);

  localparam int DW         = DRAM_DATA_WIDTH;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [FIFO_DEPTH_LOG:0] ROOM_MAX  = (FIFO_DEPTH_LOG+1)'(FIFO_DEPTH - BURST_LEN);
  localparam logic [15:0]             WAIT_LAST = 16'(READ_LATENCY - 1);

  mig_state_t                 state;
  logic [MEM_DEPTH_LOG-1:0]   base;
  logic [BEAT_W-1:0]          beat;
  logic [15:0]                wait_cnt;
  logic [DW-1:0]              store [1 << MEM_DEPTH_LOG];
  logic [MEM_DEPTH_LOG-1:0]   mem_addr;

  logic                       wr_empty;
  logic                       wr_pop;
  logic [DW:0]                wr_head;
  logic [FIFO_DEPTH_LOG:0]    wr_count_unused;
  logic                       rd_push;
  logic                       rd_pop_ok;
  logic [DW-1:0]              rd_head;
  logic [FIFO_DEPTH_LOG:0]    rd_count;
  logic [FIFO_DEPTH_LOG:0]    rd_count_next;
  logic                       rd_full_unused;
  logic                       room_next;
  logic                       accept;
  logic                       addr_unused;

  // Command handshake: a command transfers on a rising edge where MIGEn=1 and MIGRdy=1;
  // MIGRdy never depends on MIGEn, and the command fields are sampled only on that edge.
  assign accept      = MIGEn && MIGRdy;
  assign mem_addr    = base + MEM_DEPTH_LOG'(beat);
  assign wr_pop      = (state == WRITE) && !wr_empty;
  assign rd_push     = (state == READ);
  assign rd_pop_ok   = RdEn && !RdEmpty;
  assign RdData      = RdEmpty ? '0 : rd_head;
  assign dbg_state   = state;
  assign addr_unused = ^MIGAddr[DRAM_ADDR_WIDTH-1:MEM_DEPTH_LOG];

  sync_fifo #(.WIDTH(DW + 1), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_wr_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (WrEn),
    .push_data ({WrDataEnd, WrData}),
    .pop       (wr_pop),
    .pop_data  (wr_head),
    .empty     (wr_empty),
    .full      (WrFull),
    .count     (wr_count_unused)
  );

  sync_fifo #(.WIDTH(DW), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_rd_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (rd_push),
    .push_data (store[mem_addr]),
    .pop       (RdEn),
    .pop_data  (rd_head),
    .empty     (RdEmpty),
    .full      (rd_full_unused),
    .count     (rd_count)
  );

  // MIGRdy is registered, so its readiness test looks at the read FIFO level after this edge.
  always_comb begin
    rd_count_next = rd_count;
    if (rd_push && !rd_pop_ok)      rd_count_next = rd_count + (FIFO_DEPTH_LOG+1)'(1);
    else if (!rd_push && rd_pop_ok) rd_count_next = rd_count - (FIFO_DEPTH_LOG+1)'(1);
  end

  assign room_next = (rd_count_next <= ROOM_MAX);

  always_ff @(posedge Clock) begin
    if (wr_pop) store[mem_addr] <= wr_head[DW-1:0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      MIGRdy   <= 1'b0;
      ProtoErr <= 1'b0;
      base     <= '0;
      beat     <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          MIGRdy <= room_next;
          if (accept) begin
            base     <= MIGAddr[MEM_DEPTH_LOG-1:0];
            beat     <= '0;
            wait_cnt <= '0;
            if (MIGInstr == MIG_CMD_WRITE) begin
              state  <= WRITE;
              MIGRdy <= 1'b0;
            end else if (MIGInstr == MIG_CMD_READ) begin
              if (READ_LATENCY == 0) state <= READ;
              else                   state <= RDWAIT;
              MIGRdy <= 1'b0;
            end else begin
              ProtoErr <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_pop) begin
            beat <= beat + BEAT_W'(1);
            if (wr_head[DW] != (beat == LAST_BEAT)) ProtoErr <= 1'b1;
            if (beat == LAST_BEAT) begin
              state  <= IDLE;
              MIGRdy <= room_next;
            end
          end
        end
        RDWAIT: begin
          if (wait_cnt == WAIT_LAST) state <= READ;
          else                       wait_cnt <= wait_cnt + 16'd1;
        end
        READ: begin
          beat <= beat + BEAT_W'(1);
          if (beat == LAST_BEAT) begin
            state  <= IDLE;
            MIGRdy <= room_next;
          end
        end
        default: state <= IDLE;
      endcase
      if ((WrEn && WrFull) || (RdEn && RdEmpty)) ProtoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_responder.sv
// Directed bench for mig_responder: read beats are checked by a monitor against an
// expected queue filled by the stimulus; timing/flag checks are made inline.
module tb_mig_responder;
  import mig_responder_pkg::*;

  localparam int AW = 30;
  localparam int DW = 128;
  localparam int RL = 8;
  localparam int BL = 4;

  logic          Clock;
  logic          Reset;
  logic          MIGRdy;
  logic          MIGEn;
  logic [2:0]    MIGInstr;
  logic [AW-1:0] MIGAddr;
  logic          WrEn;
  logic [DW-1:0] WrData;
  logic          WrDataEnd;
  logic          WrFull;
  logic          RdEn;
  logic [DW-1:0] RdData;
  logic          RdEmpty;
  logic          ProtoErr;
  mig_state_t    dbg_state;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic          auto_pop = 1'b1;
  logic          force_rd = 1'b0;
  logic [DW-1:0] exp_q[$];

  mig_responder #(
    .DRAM_ADDR_WIDTH (AW),
    .DRAM_DATA_WIDTH (DW),
    .MEM_DEPTH_LOG   (10),
    .BURST_LEN       (BL),
    .READ_LATENCY    (RL),
    .FIFO_DEPTH_LOG  (3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MIGRdy    (MIGRdy),
    .MIGEn     (MIGEn),
    .MIGInstr  (MIGInstr),
    .MIGAddr   (MIGAddr),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .WrDataEnd (WrDataEnd),
    .WrFull    (WrFull),
    .RdEn      (RdEn),
    .RdData    (RdData),
    .RdEmpty   (RdEmpty),
    .ProtoErr  (ProtoErr),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic checkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops every presented read beat and compares it with the queue head
  initial begin
    RdEn = 1'b0;
    forever begin
      @(negedge Clock);
      RdEn = force_rd;
      if (auto_pop && !Reset && !RdEmpty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got beat %0h required no beat", RdData);
        end else begin
          checkd("rd_data", RdData, exp_q.pop_front());
        end
        RdEn = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    exp_q.delete();
    Reset = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic last);
    WrEn      = 1'b1;
    WrData    = d;
    WrDataEnd = last;
    tick();
    WrEn      = 1'b0;
    WrDataEnd = 1'b0;
  endtask

  task automatic issue_cmd(input logic [2:0] instr, input logic [AW-1:0] addr, output int t0);
    int n = 0;
    while (!MIGRdy && n < 200) begin
      tick();
      n++;
    end
    if (!MIGRdy) begin
      checks++;
      failures++;
      $display("FAIL cmd_timeout: MIGRdy=%0b required 1", MIGRdy);
    end
    MIGEn    = 1'b1;
    MIGInstr = instr;
    MIGAddr  = addr;
    tick();
    t0    = cyc;
    MIGEn = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [DW-1:0] d0);
    int t0;
    for (int i = 0; i < BL; i++) push_beat(d0 + DW'(i), i == BL - 1);
    issue_cmd(MIG_CMD_WRITE, addr, t0);
  endtask

  task automatic expect_burst(input logic [DW-1:0] d0);
    for (int i = 0; i < BL; i++) exp_q.push_back(d0 + DW'(i));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !MIGRdy) && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !MIGRdy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d beats outstanding, MIGRdy=%0b, required 0 and 1",
               exp_q.size(), MIGRdy);
    end
  endtask

  initial begin
    int t0;
    Reset = 1'b1; MIGEn = 1'b0; MIGInstr = 3'b000; MIGAddr = '0;
    WrEn = 1'b0; WrData = '0; WrDataEnd = 1'b0;
    tick();
    tick();
    check1("rst_migrdy", MIGRdy, 1'b0);
    check1("rst_wrfull", WrFull, 1'b0);
    check1("rst_rdempty", RdEmpty, 1'b1);
    checkd("rst_rddata", RdData, '0);
    check1("rst_protoerr", ProtoErr, 1'b0);
    check1("rst_state_idle", dbg_state == IDLE, 1'b1);
    Reset = 1'b0;
    tick();
    check1("rdy_after_release", MIGRdy, 1'b1);

    // basic write then read back at 0x10
    write_burst('h10, 'hA0);
    expect_burst('hA0);
    issue_cmd(MIG_CMD_READ, 'h10, t0);
    drain();
    check1("proto_clean", ProtoErr, 1'b0);

    // read latency and MIGRdy window, sampled after edges t0 .. t0+RL+BL
    expect_burst('hA0);
    issue_cmd(MIG_CMD_READ, 'h10, t0);
    for (int i = 0; i <= RL + BL; i++) begin
      check1($sformatf("lat_rdempty_%0d", i), RdEmpty, i <= RL);
      check1($sformatf("lat_migrdy_%0d", i), MIGRdy, i == RL + BL);
      check1($sformatf("lat_edge_%0d", i), cyc == t0 + i, 1'b1);
      if (i < RL + BL) tick();
    end
    drain();

    // address wrap at the top of the backing store
    write_burst('h002, 'hC0);
    write_burst('h3FE, 'hB0);
    expect_burst('hB0);
    issue_cmd(MIG_CMD_READ, 'h3FE, t0);
    exp_q.push_back('hB2); exp_q.push_back('hB3);
    exp_q.push_back('hC0); exp_q.push_back('hC1);
    issue_cmd(MIG_CMD_READ, 'h000, t0);
    drain();
    check1("proto_after_wrap", ProtoErr, 1'b0);

    // write FIFO overflow: ninth beat dropped
    do_reset();
    for (int i = 0; i < 8; i++) push_beat(DW'('hE0 + i), (i == 3) || (i == 7));
    check1("wrfull_after_8", WrFull, 1'b1);
    check1("proto_before_9th", ProtoErr, 1'b0);
    push_beat('hEE, 1'b1);
    check1("wrfull_after_9th", WrFull, 1'b1);
    check1("proto_after_9th", ProtoErr, 1'b1);
    issue_cmd(MIG_CMD_WRITE, 'h40, t0);
    issue_cmd(MIG_CMD_WRITE, 'h44, t0);
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'('hE0 + i));
    issue_cmd(MIG_CMD_READ, 'h40, t0);
    issue_cmd(MIG_CMD_READ, 'h44, t0);
    drain();
    check1("wrfull_cleared", WrFull, 1'b0);

    // WrDataEnd on beat 2 of 4: error flagged, data still stored
    do_reset();
    check1("proto_cleared_by_reset", ProtoErr, 1'b0);
    push_beat('hD0, 1'b0);
    push_beat('hD1, 1'b1);
    push_beat('hD2, 1'b0);
    push_beat('hD3, 1'b0);
    issue_cmd(MIG_CMD_WRITE, 'h20, t0);
    drain();
    check1("proto_bad_end", ProtoErr, 1'b1);
    expect_burst('hD0);
    issue_cmd(MIG_CMD_READ, 'h20, t0);
    drain();

    // unknown command encoding
    do_reset();
    issue_cmd(3'b111, 'h20, t0);
    check1("bad_instr_proto", ProtoErr, 1'b1);
    check1("bad_instr_rdy", MIGRdy, 1'b1);
    check1("bad_instr_idle", dbg_state == IDLE, 1'b1);
    expect_burst('hD0);
    issue_cmd(MIG_CMD_READ, 'h20, t0);
    drain();

    // RdEn while the read FIFO is empty
    do_reset();
    tick();
    check1("proto_pre_rden", ProtoErr, 1'b0);
    force_rd = 1'b1;
    @(negedge Clock);
    #1;
    force_rd = 1'b0;
    tick();
    check1("proto_rden_empty", ProtoErr, 1'b1);

    // reset during the second read beat
    do_reset();
    auto_pop = 1'b0;
    tick();
    issue_cmd(MIG_CMD_READ, 'h10, t0);
    repeat (RL + 2) tick();
    check1("pre_reset_nonempty", RdEmpty, 1'b0);
    checkd("pre_reset_head", RdData, 'hA0);
    Reset = 1'b1;
    #1;
    check1("midburst_rst_rdempty", RdEmpty, 1'b1);
    checkd("midburst_rst_rddata", RdData, '0);
    check1("midburst_rst_migrdy", MIGRdy, 1'b0);
    tick();
    Reset = 1'b0;
    tick();
    check1("midburst_rdy_after_release", MIGRdy, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check1($sformatf("midburst_no_beat_%0d", i), RdEmpty, 1'b1);
      tick();
    end
    auto_pop = 1'b1;

    check1("scoreboard_empty", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
